// File: rtl/oam_dma.sv
// oam_dma: sprite DMA that snoops $4014 writes, halts the CPU and copies one page to OAM.
// Optional macro OAM_DMA_ODD_ALIGN_EN adds an ALIGN cycle so every READ lands on a get cycle.
module oam_dma #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR = 16'h2004
) (
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_r_nw,
  input  logic [7:0]  bus_data_in,
  output logic        cpu_rdy,
  output logic        dma_bus_en,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_data_out,
  output logic        dma_r_nw,
  output logic        dma_active
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HALT  = 3'd1;
  localparam logic [2:0] S_ALIGN = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  logic [2:0]  r_state;
  logic [7:0]  r_page;
  logic [7:0]  r_idx;
  logic [7:0]  r_latch;
  logic        r_cpu_rdy;
  logic        r_dma_active;
  logic [15:0] r_last_addr;

  logic        w_trigger;
  logic        w_bus_en;
  logic [15:0] w_addr;
  logic [2:0]  w_halt_next;

  assign w_trigger = (r_state == S_IDLE) && !cpu_r_nw && (cpu_addr == TRIG_ADDR);
  assign w_bus_en  = (r_state == S_READ) || (r_state == S_WRITE);

  // Address holds its previous value whenever the DMA is not driving the bus.
  assign w_addr = (r_state == S_READ)  ? {r_page, r_idx} :
                  (r_state == S_WRITE) ? DEST_ADDR : r_last_addr;

`ifdef OAM_DMA_ODD_ALIGN_EN
  logic r_parity;

  // parity=0 is a get cycle; a halt on a get cycle needs one more dummy cycle.
  always_ff @(posedge clk_ph1 or posedge rst) begin
    if (rst) r_parity <= 1'b0;
    else     r_parity <= ~r_parity;
  end

  assign w_halt_next = r_parity ? S_READ : S_ALIGN;
`else
  assign w_halt_next = S_READ;
`endif

  always_ff @(posedge clk_ph1 or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_page       <= 8'h00;
      r_idx        <= 8'h00;
      r_latch      <= 8'h00;
      r_cpu_rdy    <= 1'b1;
      r_dma_active <= 1'b0;
      r_last_addr  <= 16'h0000;
    end else begin
      r_last_addr <= w_addr;
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_page       <= cpu_data_out;
            r_idx        <= 8'h00;
            r_state      <= S_HALT;
            r_cpu_rdy    <= 1'b0;
            r_dma_active <= 1'b1;
          end
        end
        // The CPU only stops on a read cycle, so wait out any writes here.
        S_HALT: begin
          if (cpu_r_nw) r_state <= w_halt_next;
        end
        S_ALIGN: r_state <= S_READ;
        S_READ: begin
          r_latch <= bus_data_in;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          if (r_idx == 8'hFF) begin
            r_state      <= S_IDLE;
            r_cpu_rdy    <= 1'b1;
            r_dma_active <= 1'b0;
          end else begin
            r_idx   <= r_idx + 8'd1;
            r_state <= S_READ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cpu_rdy      = r_cpu_rdy;
  assign dma_active   = r_dma_active;
  assign dma_bus_en   = w_bus_en;
  assign dma_addr     = w_addr;
  assign dma_data_out = r_latch;
  assign dma_r_nw     = (r_state != S_WRITE);

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: randomized OAM DMA transfers checked by a scoreboard of expected bus accesses
// and expected cpu_rdy-low durations, popped by a monitor on the falling clock edge.
module tb_oam_dma;

  logic        clk_ph1 = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_r_nw;
  logic [7:0]  bus_data_in;
  logic        cpu_rdy;
  logic        dma_bus_en;
  logic [15:0] dma_addr;
  logic [7:0]  dma_data_out;
  logic        dma_r_nw;
  logic        dma_active;

  typedef struct {
    logic [15:0] addr;
    logic        rnw;
    logic [7:0]  data;
  } acc_t;

  acc_t exp_q[$];
  int   len_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ecount;
  int   run_len = 0;
  logic [7:0] g_salt = 8'h00;
  logic [7:0] junk = 8'h00;

  oam_dma dut (
    .clk_ph1      (clk_ph1),
    .rst          (rst),
    .cpu_addr     (cpu_addr),
    .cpu_data_out (cpu_data_out),
    .cpu_r_nw     (cpu_r_nw),
    .bus_data_in  (bus_data_in),
    .cpu_rdy      (cpu_rdy),
    .dma_bus_en   (dma_bus_en),
    .dma_addr     (dma_addr),
    .dma_data_out (dma_data_out),
    .dma_r_nw     (dma_r_nw),
    .dma_active   (dma_active)
  );

  always #5 clk_ph1 = ~clk_ph1;

  // Memory map model: a DMA read of address A returns A[7:0]^5A^salt; anything else sees junk.
  assign bus_data_in = (dma_bus_en && dma_r_nw) ? (dma_addr[7:0] ^ 8'h5A ^ g_salt) : junk;

  // Clock edges since reset release; its low bit is the get/put parity of the current cycle.
  always @(posedge clk_ph1 or posedge rst) begin
    if (rst) ecount <= 0;
    else     ecount <= ecount + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every DMA bus cycle pops one expected access; every rdy-low run pops one length.
  always @(negedge clk_ph1) begin
    acc_t e;
    if (rst) begin
      run_len = 0;
    end else begin
      if (dma_bus_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_access_addr", int'(dma_addr), -1);
        end else begin
          e = exp_q.pop_front();
          chk("acc_addr", int'(dma_addr), int'(e.addr));
          chk("acc_rnw", int'(dma_r_nw), int'(e.rnw));
          if (!e.rnw) chk("acc_wdata", int'(dma_data_out), int'(e.data));
          $display("access addr=%04h rnw=%0d data=%02h", dma_addr, dma_r_nw, dma_data_out);
        end
      end
      if (!cpu_rdy) begin
        run_len++;
      end else if (run_len > 0) begin
        if (len_q.size() == 0) chk("unexpected_halt_len", run_len, 0);
        else                   chk("rdy_low_len", run_len, len_q.pop_front());
        $display("halt ended after %0d cycles", run_len);
        run_len = 0;
      end
    end
  end

  task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic rnw);
    cpu_addr     = a;
    cpu_data_out = d;
    cpu_r_nw     = rnw;
    junk         = 8'($urandom);
    @(posedge clk_ph1);
    #1;
  endtask

  task automatic idle_read();
    logic [15:0] a;
    a = 16'($urandom);
    if (a == 16'h4014) a = 16'h0000;
    cyc(a, 8'($urandom), 1'b1);
  endtask

  // want_par: 0/1 forces the halt-cycle parity, 2 leaves it to chance.
  task automatic run_dma(input logic [7:0] page, input int nwait, input int want_par,
                         input logic [7:0] salt, input bit abort80);
    int  hp, align, k;
    bit  done;
    acc_t e;
    if (want_par < 2 && ((ecount + 1 + nwait) % 2) != want_par) idle_read();
    g_salt = salt;
    for (int i = 0; i < 256; i++) begin
      e.addr = {page, 8'(i)}; e.rnw = 1'b1; e.data = 8'h00;
      exp_q.push_back(e);
      e.addr = 16'h2004; e.rnw = 1'b0; e.data = 8'(i) ^ 8'h5A ^ salt;
      exp_q.push_back(e);
    end
    $display("trigger page=%02h wait=%0d salt=%02h", page, nwait, salt);
    cyc(16'h4014, page, 1'b0);
    chk("rdy_fall", int'(cpu_rdy), 0);
    chk("active_rise", int'(dma_active), 1);
    for (int w = 0; w < nwait; w++)
      cyc((w == 0) ? 16'h4014 : 16'h01F0 + 16'(w), 8'($urandom), 1'b0);
    hp = ecount % 2;
`ifdef OAM_DMA_ODD_ALIGN_EN
    align = (hp == 0) ? 1 : 0;
`else
    align = 0;
`endif
    len_q.push_back(nwait + 1 + align + 512);
    done = 0;
    for (k = 0; k < 700 && !done; k++) begin
      if (abort80 && dma_bus_en && dma_r_nw && dma_addr[7:0] == 8'h80) begin
        rst = 1'b1;
        #2;
        chk("abort_rdy", int'(cpu_rdy), 1);
        chk("abort_bus_en", int'(dma_bus_en), 0);
        chk("abort_active", int'(dma_active), 0);
        exp_q.delete();
        len_q.delete();
        @(posedge clk_ph1);
        #1;
        rst = 1'b0;
        $display("reset applied at idx 80");
        done = 1;
      end else if (!dma_active) begin
        done = 1;
      end else begin
        idle_read();
      end
    end
    if (!done) chk("dma_timeout", k, 0);
    idle_read();
    idle_read();
    chk("exp_q_drained", exp_q.size(), 0);
    chk("len_q_drained", len_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    cpu_addr = 16'h0000; cpu_data_out = 8'h00; cpu_r_nw = 1'b1;
    @(posedge clk_ph1); @(posedge clk_ph1); #1;
    rst = 1'b0;
    chk("reset_rdy", int'(cpu_rdy), 1);
    chk("reset_bus_en", int'(dma_bus_en), 0);
    chk("reset_active", int'(dma_active), 0);
    chk("reset_r_nw", int'(dma_r_nw), 1);
    chk("reset_addr", int'(dma_addr), 0);
    chk("reset_data", int'(dma_data_out), 0);
    idle_read();

    run_dma(8'h02, 0, 1, 8'h00, 0);
    run_dma(8'h02, 0, 0, 8'h00, 0);
    run_dma(8'h03, 2, 2, 8'($urandom), 0);
    run_dma(8'h07, 0, 2, 8'($urandom), 1);
    run_dma(8'h05, 0, 2, 8'($urandom), 0);

    cyc(16'h4014, 8'h33, 1'b1);
    cyc(16'h4015, 8'h33, 1'b0);
    idle_read();
    chk("nontrig_active", int'(dma_active), 0);
    chk("nontrig_rdy", int'(cpu_rdy), 1);
    chk("nontrig_bus_en", int'(dma_bus_en), 0);

    run_dma(8'hFF, 0, 2, 8'($urandom), 0);
    for (int n = 0; n < 3; n++)
      run_dma(8'($urandom), int'($urandom_range(0, 3)), 2, 8'($urandom), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
